// File: rtl/cu_setup_response_decoder.sv
// Packs memory response words into configuration records and drains responses during a flush.
// Optional macro SETUP_RESP_CHECK_EN: accept and flag stray response beats while IDLE or DONE.
module cu_setup_response_decoder #(
    parameter int DATA_W        = 32,
    parameter int NUM_CFG_WORDS = 4,
    parameter int CNT_W         = 16,
    parameter int FLUSH_QUIET   = 8
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            setup_start,
    input  logic [CNT_W-1:0]                setup_num_words,
    input  logic                            flush_start,
    input  logic                            resp_in_valid,
    output logic                            resp_in_ready,
    input  logic [DATA_W-1:0]               resp_in_data,
    output logic                            cfg_out_valid,
    input  logic                            cfg_out_ready,
    output logic [NUM_CFG_WORDS*DATA_W-1:0] cfg_out_data,
    output logic                            setup_done,
    output logic                            flush_done,
    output logic [7:0]                      resp_state,
    output logic                            resp_error
);

    localparam int SLOT_W  = $clog2(NUM_CFG_WORDS);
    localparam int QUIET_W = $clog2(FLUSH_QUIET + 1);

    typedef enum logic [7:0] {
        RESP_RESET = 8'h01,
        RESP_IDLE  = 8'h02,
        RESP_START = 8'h04,
        RESP_BUSY  = 8'h08,
        RESP_PAUSE = 8'h10,
        RESP_DONE  = 8'h20,
        FLUSH_BUSY = 8'h40,
        FLUSH_DONE = 8'h80
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [QUIET_W-1:0]   quiet_q, quiet_d;
    logic [DATA_W-1:0]    rec_q [NUM_CFG_WORDS];
    logic [DATA_W-1:0]    rec_d [NUM_CFG_WORDS];
    logic                 idle_like;
    logic                 start_take;
    logic                 resp_accept;

    assign idle_like   = (state_q == RESP_IDLE) || (state_q == RESP_DONE);
    assign start_take  = setup_start && idle_like && !flush_start;
    assign resp_accept = resp_in_valid && resp_in_ready;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    // All outputs decode from registered state only.
`ifdef SETUP_RESP_CHECK_EN
    assign resp_in_ready = (state_q == RESP_BUSY) || (state_q == FLUSH_BUSY) || idle_like;
`else
    assign resp_in_ready = (state_q == RESP_BUSY) || (state_q == FLUSH_BUSY);
`endif
    assign cfg_out_valid = (state_q == RESP_PAUSE);
    assign setup_done    = (state_q == RESP_DONE);
    assign flush_done    = (state_q == FLUSH_DONE);
    assign resp_state    = state_q;

    for (genvar gi = 0; gi < NUM_CFG_WORDS; gi++) begin : g_pack
        assign cfg_out_data[gi*DATA_W +: DATA_W] = rec_q[gi];
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        quiet_d = quiet_q;
        rec_d   = rec_q;
        if (start_take) begin
            num_d = setup_num_words;
        end
        case (state_q)
            RESP_RESET: state_d = RESP_IDLE;
            RESP_IDLE, RESP_DONE: begin
                if (setup_start) begin
                    state_d = RESP_START;
                end
            end
            RESP_START: begin
                cnt_d  = '0;
                slot_d = '0;
                for (int i = 0; i < NUM_CFG_WORDS; i++) begin
                    rec_d[i] = '0;
                end
                state_d = (num_q == '0) ? RESP_DONE : RESP_BUSY;
            end
            RESP_BUSY: begin
                if (resp_accept) begin
                    rec_d[slot_q] = resp_in_data;
                    slot_d        = slot_q + SLOT_W'(1);
                    cnt_d         = cnt_inc;
                    if ((slot_q == SLOT_W'(NUM_CFG_WORDS - 1)) || (cnt_inc == num_q)) begin
                        state_d = RESP_PAUSE;
                    end
                end
            end
            RESP_PAUSE: begin
                if (cfg_out_ready) begin
                    slot_d = '0;
                    for (int i = 0; i < NUM_CFG_WORDS; i++) begin
                        rec_d[i] = '0;
                    end
                    state_d = (cnt_q == num_q) ? RESP_DONE : RESP_BUSY;
                end
            end
            FLUSH_BUSY: begin
                // Any beat restarts the quiet window; beats themselves are dropped.
                if (resp_in_valid) begin
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + QUIET_W'(1);
                    if (quiet_q == QUIET_W'(FLUSH_QUIET - 1)) begin
                        state_d = FLUSH_DONE;
                    end
                end
            end
            FLUSH_DONE: state_d = RESP_IDLE;
            default:    state_d = RESP_IDLE;
        endcase
        if (flush_start && (state_q != RESP_RESET)) begin
            state_d = FLUSH_BUSY;
            quiet_d = '0;
            slot_d  = '0;
            for (int i = 0; i < NUM_CFG_WORDS; i++) begin
                rec_d[i] = '0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= RESP_RESET;
            num_q   <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            quiet_q <= '0;
            for (int i = 0; i < NUM_CFG_WORDS; i++) begin
                rec_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            quiet_q <= quiet_d;
            for (int i = 0; i < NUM_CFG_WORDS; i++) begin
                rec_q[i] <= rec_d[i];
            end
        end
    end

`ifdef SETUP_RESP_CHECK_EN
    logic err_q, err_d;

    // A stray beat in the same cycle as a new start still counts as an error.
    always_comb begin
        err_d = err_q;
        if (start_take) begin
            err_d = 1'b0;
        end
        if (idle_like && resp_accept) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign resp_error = err_q;
`else
    assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_cu_setup_response_decoder.sv
// Directed bench for cu_setup_response_decoder: record table runs plus timing, flush,
// stray-beat and mid-run reset sequences.
module tb_cu_setup_response_decoder;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int CW = 16;
    localparam int FQ = 8;

    localparam logic [7:0] S_RESET = 8'h01;
    localparam logic [7:0] S_IDLE  = 8'h02;
    localparam logic [7:0] S_START = 8'h04;
    localparam logic [7:0] S_BUSY  = 8'h08;
    localparam logic [7:0] S_DONE  = 8'h20;
    localparam logic [7:0] S_FBUSY = 8'h40;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              setup_start;
    logic [CW-1:0]     setup_num_words;
    logic              flush_start;
    logic              resp_in_valid;
    logic              resp_in_ready;
    logic [DW-1:0]     resp_in_data;
    logic              cfg_out_valid;
    logic              cfg_out_ready;
    logic [NW*DW-1:0]  cfg_out_data;
    logic              setup_done;
    logic              flush_done;
    logic [7:0]        resp_state;
    logic              resp_error;

    int checks   = 0;
    int failures = 0;

    cu_setup_response_decoder #(
        .DATA_W(DW), .NUM_CFG_WORDS(NW), .CNT_W(CW), .FLUSH_QUIET(FQ)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .setup_start(setup_start),
        .setup_num_words(setup_num_words),
        .flush_start(flush_start),
        .resp_in_valid(resp_in_valid),
        .resp_in_ready(resp_in_ready),
        .resp_in_data(resp_in_data),
        .cfg_out_valid(cfg_out_valid),
        .cfg_out_ready(cfg_out_ready),
        .cfg_out_data(cfg_out_data),
        .setup_done(setup_done),
        .flush_done(flush_done),
        .resp_state(resp_state),
        .resp_error(resp_error)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct {
        int           num;
        int           stall;
        int           exp_nrec;
        logic [127:0] exp_rec0;
        logic [127:0] exp_rec1;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int n);
        @(negedge ap_clk);
        setup_num_words = CW'(n);
        setup_start     = 1'b1;
        @(negedge ap_clk);
        setup_start     = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int           sent;
        int           nrec;
        int           stalled;
        logic         done;
        logic         held_v;
        logic [127:0] held;
        logic [127:0] recs [4];
        sent    = 0;
        nrec    = 0;
        stalled = 0;
        done    = 1'b0;
        held_v  = 1'b0;
        held    = '0;
        pulse_start(v.num);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) @(negedge ap_clk);
            resp_in_valid = (sent < v.num);
            resp_in_data  = 32'h10 + 32'(sent);
            cfg_out_ready = 1'b1;
            if (cfg_out_valid) begin
                chk("pause_ready_low", 128'(resp_in_ready), 128'(0));
                if (held_v) chk("rec_stable", 128'(cfg_out_data), held);
                held   = 128'(cfg_out_data);
                held_v = 1'b1;
                if (nrec == 0 && stalled < v.stall) begin
                    cfg_out_ready = 1'b0;
                    stalled++;
                end
            end
            if (resp_in_valid && resp_in_ready) sent++;
            if (cfg_out_valid && cfg_out_ready) begin
                if (nrec < 4) recs[nrec] = 128'(cfg_out_data);
                $display("run %0d record %0d data=%h", idx, nrec, cfg_out_data);
                nrec++;
                held_v = 1'b0;
            end
            if (setup_done) done = 1'b1;
        end
        resp_in_valid = 1'b0;
        cfg_out_ready = 1'b0;
        $display("run %0d num=%0d stall=%0d words=%0d records=%0d", idx, v.num, v.stall, sent, nrec);
        chk("run_done", 128'(done), 128'(1));
        chk("run_nrec", 128'(nrec), 128'(v.exp_nrec));
        chk("run_words", 128'(sent), 128'(v.num));
        chk("run_rec0", recs[0], v.exp_rec0);
        chk("run_rec1", recs[1], v.exp_rec1);
    endtask

    initial begin
        int   seen;
        int   ndone;
        logic saw_valid;

        vecs[0] = '{8, 0, 2, 128'h00000013_00000012_00000011_00000010,
                              128'h00000017_00000016_00000015_00000014};
        vecs[1] = '{6, 0, 2, 128'h00000013_00000012_00000011_00000010,
                              128'h00000000_00000000_00000015_00000014};
        vecs[2] = '{8, 5, 2, 128'h00000013_00000012_00000011_00000010,
                              128'h00000017_00000016_00000015_00000014};
        vecs[3] = '{5, 0, 2, 128'h00000013_00000012_00000011_00000010,
                              128'h00000000_00000000_00000000_00000014};

        ap_rst_n        = 1'b0;
        setup_start     = 1'b0;
        setup_num_words = '0;
        flush_start     = 1'b0;
        resp_in_valid   = 1'b0;
        resp_in_data    = '0;
        cfg_out_ready   = 1'b0;

        // Reset values
        repeat (2) @(negedge ap_clk);
        chk("rst_state", 128'(resp_state), 128'(S_RESET));
        chk("rst_ready", 128'(resp_in_ready), 128'(0));
        chk("rst_valid", 128'(cfg_out_valid), 128'(0));
        chk("rst_data", 128'(cfg_out_data), 128'(0));
        chk("rst_sdone", 128'(setup_done), 128'(0));
        chk("rst_fdone", 128'(flush_done), 128'(0));
        chk("rst_err", 128'(resp_error), 128'(0));
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_to_idle", 128'(resp_state), 128'(S_IDLE));
        $display("reset sequence done");

        // Stray beat while IDLE
        resp_in_valid = 1'b1;
        resp_in_data  = 32'hdead_beef;
`ifdef SETUP_RESP_CHECK_EN
        chk("stray_ready", 128'(resp_in_ready), 128'(1));
`else
        chk("stray_ready", 128'(resp_in_ready), 128'(0));
`endif
        @(negedge ap_clk);
        resp_in_valid = 1'b0;
`ifdef SETUP_RESP_CHECK_EN
        chk("stray_err", 128'(resp_error), 128'(1));
`else
        chk("stray_err", 128'(resp_error), 128'(0));
`endif
        $display("stray beat in IDLE: error=%0b", resp_error);

        // Zero-length run also clears the error flag
        pulse_start(0);
        chk("zero_start", 128'(resp_state), 128'(S_START));
        chk("zero_err_clr", 128'(resp_error), 128'(0));
        chk("zero_valid0", 128'(cfg_out_valid), 128'(0));
        @(negedge ap_clk);
        chk("zero_done_state", 128'(resp_state), 128'(S_DONE));
        chk("zero_done", 128'(setup_done), 128'(1));
        chk("zero_valid1", 128'(cfg_out_valid), 128'(0));
        $display("zero-length run done");

        // Latency: START at t+1, BUSY/ready at t+2, record valid one cycle after last word
        pulse_start(4);
        chk("lat_start", 128'(resp_state), 128'(S_START));
        chk("lat_start_ready", 128'(resp_in_ready), 128'(0));
        @(negedge ap_clk);
        chk("lat_busy", 128'(resp_state), 128'(S_BUSY));
        for (int w = 0; w < 4; w++) begin
            resp_in_valid = 1'b1;
            resp_in_data  = 32'h10 + 32'(w);
            chk("lat_ready", 128'(resp_in_ready), 128'(1));
            chk("lat_novalid", 128'(cfg_out_valid), 128'(0));
            @(negedge ap_clk);
        end
        resp_in_valid = 1'b0;
        chk("lat_valid", 128'(cfg_out_valid), 128'(1));
        chk("lat_data", 128'(cfg_out_data), 128'h00000013_00000012_00000011_00000010);
        cfg_out_ready = 1'b1;
        @(negedge ap_clk);
        cfg_out_ready = 1'b0;
        chk("lat_valid_drop", 128'(cfg_out_valid), 128'(0));
        chk("lat_sdone", 128'(setup_done), 128'(1));
        $display("latency run done");

        // Table-driven record runs
        for (int i = 0; i < 4; i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush after 3 of 8 words, two more beats, then quiet
        saw_valid = 1'b0;
        pulse_start(8);
        @(negedge ap_clk);
        for (int w = 0; w < 3; w++) begin
            resp_in_valid = 1'b1;
            resp_in_data  = 32'h10 + 32'(w);
            if (cfg_out_valid) saw_valid = 1'b1;
            @(negedge ap_clk);
        end
        resp_in_valid = 1'b0;
        flush_start   = 1'b1;
        @(negedge ap_clk);
        flush_start   = 1'b0;
        chk("flush_state", 128'(resp_state), 128'(S_FBUSY));
        chk("flush_ready", 128'(resp_in_ready), 128'(1));
        resp_in_valid = 1'b1;
        resp_in_data  = 32'h55;
        @(negedge ap_clk);
        if (cfg_out_valid) saw_valid = 1'b1;
        resp_in_data  = 32'h56;
        @(negedge ap_clk);
        resp_in_valid = 1'b0;
        seen  = -1;
        ndone = 0;
        for (int i = 0; i < 3 * FQ + 4; i++) begin
            if (flush_done) begin
                if (seen < 0) seen = i;
                ndone++;
            end
            if (cfg_out_valid) saw_valid = 1'b1;
            @(negedge ap_clk);
        end
        $display("flush: done after %0d quiet cycles, pulses=%0d", seen, ndone);
        chk("flush_done_time", 128'(seen), 128'(FQ));
        chk("flush_done_pulses", 128'(ndone), 128'(1));
        chk("flush_no_valid", 128'(saw_valid), 128'(0));
        chk("flush_idle", 128'(resp_state), 128'(S_IDLE));

        // Asynchronous reset in the middle of a run
        pulse_start(8);
        @(negedge ap_clk);
        for (int w = 0; w < 2; w++) begin
            resp_in_valid = 1'b1;
            resp_in_data  = 32'h10 + 32'(w);
            @(negedge ap_clk);
        end
        resp_in_valid = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_state", 128'(resp_state), 128'(S_RESET));
        chk("arst_data", 128'(cfg_out_data), 128'(0));
        chk("arst_valid", 128'(cfg_out_valid), 128'(0));
        chk("arst_ready", 128'(resp_in_ready), 128'(0));
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("arst_idle", 128'(resp_state), 128'(S_IDLE));
        chk("arst_valid_after", 128'(cfg_out_valid), 128'(0));
        $display("mid-run reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cu_setup_response_decoder.md
# cu_setup_response_decoder

Response-side counterpart of the compute-unit setup requester. It consumes the configuration words returned by memory for a setup request, packs them into fixed-size configuration records, and hands each record to the CU configuration registers over a valid/ready handshake. It also executes the flush phase by draining and discarding in-flight responses. It sits between the CU memory read-response channel and the CU configuration register block.

## Interface
- DATA_W, 32, width of one response word
- NUM_CFG_WORDS, 4, words per configuration record (≥2)
- CNT_W, 16, width of the expected-word counter
- FLUSH_QUIET, 8, consecutive idle cycles that end a flush (≥1)

Ports:
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- setup_start  in  1  one-cycle pulse that begins a response run
- setup_num_words  in  CNT_W  expected word count; sampled on setup_start
- flush_start  in  1  one-cycle pulse that begins a flush
- resp_in_valid  in  1  response word valid
- resp_in_ready  out  1  response word accepted when valid & ready
- resp_in_data  in  DATA_W  response word
- cfg_out_valid  out  1  configuration record valid
- cfg_out_ready  in  1  record consumer ready
- cfg_out_data  out  NUM_CFG_WORDS*DATA_W  record; slot i at bits [i*DATA_W +: DATA_W]
- setup_done  out  1  level; run complete
- flush_done  out  1  one-cycle pulse; flush complete
- resp_state  out  8  one-hot current state
- resp_error  out  1  sticky unexpected-beat flag (see Configuration)

## Operation
- One-hot states:
  - RESP_RESET = 1<<0
  - RESP_IDLE = 1<<1
  - RESP_START = 1<<2
  - RESP_BUSY = 1<<3
  - RESP_PAUSE = 1<<4
  - RESP_DONE = 1<<5
  - FLUSH_BUSY = 1<<6
  - FLUSH_DONE = 1<<7
- RESET → IDLE unconditionally on the first clock after reset release.
- IDLE or DONE, setup_start → START. In other states setup_start is ignored.
- START:
  - Latch setup_num_words.
  - Clear the word counter, slot index and record register.
  - Next state: DONE if the count is 0, else BUSY.
- BUSY:
  - resp_in_ready = 1.
  - Each accepted word is written to the current slot, and the slot index and counter increment.
  - When the accepted word fills slot NUM_CFG_WORDS-1 or is the last expected word, go to PAUSE.
  - Unfilled slots of a final partial record read 0.
- PAUSE:
  - cfg_out_valid = 1 and resp_in_ready = 0.
  - On cfg_out_ready, clear the record and slot index.
  - Next state: DONE if the counter equals the latched count, else BUSY.
- DONE: setup_done = 1. Hold until setup_start or flush_start.
- flush_start from any state except RESET → FLUSH_BUSY.
  - It aborts a run in progress and drops cfg_out_valid.
  - It wins over a simultaneous setup_start.
- FLUSH_BUSY:
  - resp_in_ready = 1 and every beat is discarded.
  - The quiet counter clears on any resp_in_valid and otherwise increments.
  - When the quiet counter reaches FLUSH_QUIET → FLUSH_DONE.
- FLUSH_DONE: flush_done = 1 for one cycle, then IDLE.
- The word counter is CNT_W bits and never wraps: the count reaches at most setup_num_words ≤ 2^CNT_W-1.

## Timing
- Reset values of all outputs:
  - resp_in_ready = 0, cfg_out_valid = 0, cfg_out_data = 0
  - setup_done = 0, flush_done = 0, resp_error = 0
  - resp_state = RESP_RESET
- Every output is registered or decoded only from state, so there is no combinational input→output path.
- setup_start at cycle t:
  - START at t+1.
  - BUSY at t+2, with resp_in_ready = 1 at t+2.
- Record timing: the word completing a record is accepted at cycle t, so cfg_out_valid = 1 at t+1.
  - If the handshake occurs at cycle h, cfg_out_valid = 0 at h+1 and resp_in_ready = 1 at h+1 if more words remain.
- Minimum cost is NUM_CFG_WORDS+1 cycles per record.
- cfg_out_data is stable while cfg_out_valid is high.
- Flush: the last beat seen at cycle t gives flush_done at t+FLUSH_QUIET+1.
- ap_rst_n assertion mid-run clears all state asynchronously. The partial record is lost and no cfg_out_valid is emitted.

## Configuration
- SETUP_RESP_CHECK_EN defined:
  - In IDLE and DONE, resp_in_ready = 1.
  - Any accepted beat is discarded and sets resp_error.
  - resp_error stays set until the next setup_start or reset.
- SETUP_RESP_CHECK_EN undefined:
  - resp_in_ready = 0 in IDLE and DONE, so stray beats stall upstream.
  - resp_error is tied 0.

## Test plan
- Reset, then setup_num_words=8 with words 0x10..0x17 streamed back-to-back and cfg_out_ready=1 → two records {0x10..0x13} and {0x14..0x17}; setup_done rises after the second record's handshake.
- setup_num_words=6 → the second record is {0x14,0x15,0,0}; setup_done rises after its handshake.
- cfg_out_ready held 0 for 5 cycles on the first record → resp_in_ready = 0 throughout, cfg_out_data stable, no word lost, final records correct.
- setup_num_words=0 → START then DONE; cfg_out_valid never asserts.
- flush_start after 3 of 8 words, then 2 more beats, then idle → no cfg_out_valid; flush_done pulses FLUSH_QUIET+1 cycles after the last beat; state returns to IDLE.
- With SETUP_RESP_CHECK_EN: a beat in IDLE → accepted, resp_error = 1, cleared by the next setup_start. Without it: resp_in_ready = 0 and resp_error = 0.
